idu_exu_pipe_reg: RTL and testbench

- ID→EX pipeline register for the RV32I pipeline.
- Consumes the per-operand 2-bit forwarding selects from the data-hazard unit and muxes regfile, EX and MEM results into the operands latched for EX.
- Detects load-use hazards (load in EX feeding ID), holds ID and injects a one-cycle bubble; also handles branch flush and downstream back-pressure.
- Counts inserted load-use bubbles for performance tracing.

---
 rtl/idu_exu_pipe_reg.sv | 129 ++++++++++++
 tb/tb_idu_exu_pipe_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_exu_pipe_reg.sv
// idu_exu_pipe_reg: ID->EX pipeline register with operand forwarding,
// load-use bubble insertion, flush/back-pressure handling and a bubble counter
module idu_exu_pipe_reg #(
  parameter int          XLEN     = 32,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDU_valid,
  input  logic [XLEN-1:0]  IDU_pc,
  input  logic [31:0]      IDU_inst,
  input  logic [4:0]       IDU_rd,
  input  logic [XLEN-1:0]  IDU_imm,
  input  logic             IDU_R_Wen,
  input  logic             IDU_mem_ren,
  input  logic             IDU_mem_wen,
  input  logic [XLEN-1:0]  IDU_rs1_data,
  input  logic [XLEN-1:0]  IDU_rs2_data,
  input  logic [1:0]       IDU_rs1_choice,
  input  logic [1:0]       IDU_rs2_choice,
  input  logic [XLEN-1:0]  EXU_result,
  input  logic             MEM_valid,
  input  logic [XLEN-1:0]  MEM_alu_result,
  input  logic [XLEN-1:0]  MEM_rdata,
  input  logic             EXU_ready,
  input  logic             flush,
  output logic             IDU_ready,
  output logic             EXU_valid,
  output logic [XLEN-1:0]  EXU_pc,
  output logic [31:0]      EXU_inst,
  output logic [4:0]       EXU_rd,
  output logic [XLEN-1:0]  EXU_imm,
  output logic [XLEN-1:0]  EXU_rs1_val,
  output logic [XLEN-1:0]  EXU_rs2_val,
  output logic             EXU_R_Wen,
  output logic             EXU_mem_ren,
  output logic             EXU_mem_wen,
  output logic [CNT_W-1:0] load_use_cnt
);
  logic             valid_q, valid_d, rwen_q, rwen_d, mren_q, mren_d, mwen_q, mwen_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]      inst_q, inst_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             load_use;
  // a forwarding select whose source stage is empty falls back to the regfile
  always_comb begin
    rs1_fwd = (IDU_rs1_choice == 2'b01 && valid_q)   ? EXU_result     :
              (IDU_rs1_choice == 2'b10 && MEM_valid) ? MEM_alu_result :
              (IDU_rs1_choice == 2'b11 && MEM_valid) ? MEM_rdata      : IDU_rs1_data;
    rs2_fwd = (IDU_rs2_choice == 2'b01 && valid_q)   ? EXU_result     :
              (IDU_rs2_choice == 2'b10 && MEM_valid) ? MEM_alu_result :
              (IDU_rs2_choice == 2'b11 && MEM_valid) ? MEM_rdata      : IDU_rs2_data;
    load_use = IDU_valid & valid_q & mren_q & (IDU_rs1_choice == 2'b01 | IDU_rs2_choice == 2'b01);
  end
  assign IDU_ready = EXU_ready & ~load_use;
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rwen_d  = rwen_q;
    mren_d  = mren_q;
    mwen_d  = mwen_q;
    cnt_d   = cnt_q;
    if (flush || (EXU_ready && load_use)) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      rwen_d  = 1'b0;
      mren_d  = 1'b0;
      mwen_d  = 1'b0;
      cnt_d   = (!flush && ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end else if (EXU_ready) begin
      valid_d = IDU_valid;
      pc_d    = IDU_pc;
      inst_d  = IDU_valid ? IDU_inst : NOP_INST;
      rd_d    = IDU_rd;
      imm_d   = IDU_imm;
      rs1_d   = rs1_fwd;
      rs2_d   = rs2_fwd;
      rwen_d  = IDU_valid & IDU_R_Wen;
      mren_d  = IDU_valid & IDU_mem_ren;
      mwen_d  = IDU_valid & IDU_mem_wen;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      rd_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rwen_q  <= 1'b0;
      mren_q  <= 1'b0;
      mwen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rwen_q  <= rwen_d;
      mren_q  <= mren_d;
      mwen_q  <= mwen_d;
      cnt_q   <= cnt_d;
    end
  end
  assign EXU_valid    = valid_q;
  assign EXU_pc       = pc_q;
  assign EXU_inst     = inst_q;
  assign EXU_rd       = rd_q;
  assign EXU_imm      = imm_q;
  assign EXU_rs1_val  = rs1_q;
  assign EXU_rs2_val  = rs2_q;
  assign EXU_R_Wen    = rwen_q;
  assign EXU_mem_ren  = mren_q;
  assign EXU_mem_wen  = mwen_q;
  assign load_use_cnt = cnt_q;
endmodule

// File: tb/tb_idu_exu_pipe_reg.sv
// tb_idu_exu_pipe_reg: directed scenarios plus randomized traffic checked
// against a behavioural model of the ID->EX register
module tb_idu_exu_pipe_reg;
  localparam int          XLEN  = 32;
  localparam int          CNT_W = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic IDU_valid, IDU_R_Wen, IDU_mem_ren, IDU_mem_wen, MEM_valid, EXU_ready, flush;
  logic [XLEN-1:0] IDU_pc, IDU_imm, IDU_rs1_data, IDU_rs2_data, EXU_result, MEM_alu_result, MEM_rdata;
  logic [31:0] IDU_inst;
  logic [4:0]  IDU_rd;
  logic [1:0]  IDU_rs1_choice, IDU_rs2_choice;
  logic IDU_ready, EXU_valid, EXU_R_Wen, EXU_mem_ren, EXU_mem_wen;
  logic [XLEN-1:0] EXU_pc, EXU_imm, EXU_rs1_val, EXU_rs2_val;
  logic [31:0] EXU_inst;
  logic [4:0]  EXU_rd;
  logic [CNT_W-1:0] load_use_cnt;
  int checks = 0, errors = 0;
  logic m_valid, m_rwen, m_mren, m_mwen;
  logic [XLEN-1:0] m_pc, m_imm, m_rs1, m_rs2;
  logic [31:0] m_inst;
  logic [4:0]  m_rd;
  int m_cnt;
  logic ro, re;

  idu_exu_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .IDU_valid(IDU_valid), .IDU_pc(IDU_pc), .IDU_inst(IDU_inst),
    .IDU_rd(IDU_rd), .IDU_imm(IDU_imm), .IDU_R_Wen(IDU_R_Wen), .IDU_mem_ren(IDU_mem_ren),
    .IDU_mem_wen(IDU_mem_wen), .IDU_rs1_data(IDU_rs1_data), .IDU_rs2_data(IDU_rs2_data),
    .IDU_rs1_choice(IDU_rs1_choice), .IDU_rs2_choice(IDU_rs2_choice), .EXU_result(EXU_result),
    .MEM_valid(MEM_valid), .MEM_alu_result(MEM_alu_result), .MEM_rdata(MEM_rdata),
    .EXU_ready(EXU_ready), .flush(flush), .IDU_ready(IDU_ready), .EXU_valid(EXU_valid),
    .EXU_pc(EXU_pc), .EXU_inst(EXU_inst), .EXU_rd(EXU_rd), .EXU_imm(EXU_imm),
    .EXU_rs1_val(EXU_rs1_val), .EXU_rs2_val(EXU_rs2_val), .EXU_R_Wen(EXU_R_Wen),
    .EXU_mem_ren(EXU_mem_ren), .EXU_mem_wen(EXU_mem_wen), .load_use_cnt(load_use_cnt));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_rwen = 0; m_mren = 0; m_mwen = 0; m_pc = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_inst = NOP; m_rd = 0; m_cnt = 0;
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [1:0] c, input logic [XLEN-1:0] rf);
    if (c == 2'd1 && m_valid) return EXU_result;
    if (c == 2'd2 && MEM_valid) return MEM_alu_result;
    if (c == 2'd3 && MEM_valid) return MEM_rdata;
    return rf;
  endfunction

  task automatic idle();
    IDU_valid = 0; IDU_R_Wen = 0; IDU_mem_ren = 0; IDU_mem_wen = 0; MEM_valid = 0;
    EXU_ready = 1; flush = 0; IDU_pc = 0; IDU_imm = 0; IDU_rs1_data = 0; IDU_rs2_data = 0;
    EXU_result = 0; MEM_alu_result = 0; MEM_rdata = 0; IDU_inst = NOP; IDU_rd = 0;
    IDU_rs1_choice = 0; IDU_rs2_choice = 0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [31:0] inst, input logic ren,
                        input logic [1:0] c1, input logic [1:0] c2);
    IDU_valid = 1; IDU_pc = pc; IDU_inst = inst; IDU_rd = inst[11:7]; IDU_imm = pc ^ 32'h55;
    IDU_R_Wen = 1; IDU_mem_ren = ren; IDU_mem_wen = 0; IDU_rs1_choice = c1; IDU_rs2_choice = c2;
  endtask

  // One clock: samples IDU_ready before the edge, advances the model, returns at negedge
  task automatic cycle(output logic rdy_obs, output logic rdy_exp);
    logic lu;
    logic [XLEN-1:0] a1, a2;
    #1;
    lu = IDU_valid && m_valid && m_mren && (IDU_rs1_choice == 2'd1 || IDU_rs2_choice == 2'd1);
    rdy_exp = EXU_ready && !lu;
    rdy_obs = IDU_ready;
    a1 = fwd(IDU_rs1_choice, IDU_rs1_data);
    a2 = fwd(IDU_rs2_choice, IDU_rs2_data);
    @(posedge clk);
    if (flush || (EXU_ready && lu)) begin
      m_valid = 0; m_inst = NOP; m_rwen = 0; m_mren = 0; m_mwen = 0;
      if (!flush && m_cnt < CMAX) m_cnt++;
    end else if (EXU_ready) begin
      m_valid = IDU_valid; m_pc = IDU_pc; m_inst = IDU_valid ? IDU_inst : NOP; m_rd = IDU_rd;
      m_imm = IDU_imm; m_rs1 = a1; m_rs2 = a2; m_rwen = IDU_valid && IDU_R_Wen;
      m_mren = IDU_valid && IDU_mem_ren; m_mwen = IDU_valid && IDU_mem_wen;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({EXU_valid, EXU_pc, EXU_rd, EXU_imm, EXU_rs1_val, EXU_rs2_val, EXU_R_Wen, EXU_mem_ren, EXU_mem_wen, load_use_cnt} !== '0) begin
      errors++; $display("FAIL reset_zero valid=%0b pc=%0h cnt=%0d expected all zero", EXU_valid, EXU_pc, load_use_cnt);
    end
    checks++;
    if (EXU_inst !== NOP) begin errors++; $display("FAIL reset_inst got %0h exp %0h", EXU_inst, NOP); end
    EXU_ready = 0; #1; checks++;
    if (IDU_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_lo got %0b exp 0", IDU_ready); end
    EXU_ready = 1; #1; checks++;
    if (IDU_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_hi got %0b exp 1", IDU_ready); end
    @(negedge clk); rst_n = 1; model_reset();
  endtask

  task automatic test_alu_flow();
    idle(); set_id(32'h100, 32'h0020_81b3, 0, 0, 0); IDU_rs1_data = 5; IDU_rs2_data = 7;
    cycle(ro, re); checks++;
    if (ro !== 1'b1) begin errors++; $display("FAIL alu_ready got %0b exp 1", ro); end
    checks++;
    if ({EXU_valid, EXU_rs1_val, EXU_rs2_val, EXU_R_Wen, EXU_pc} !== {1'b1, 32'd5, 32'd7, 1'b1, 32'h100}) begin
      errors++; $display("FAIL alu_capture valid=%0b rs1=%0h rs2=%0h wen=%0b pc=%0h exp 1/5/7/1/100", EXU_valid, EXU_rs1_val, EXU_rs2_val, EXU_R_Wen, EXU_pc);
    end
  endtask

  task automatic test_ex_forward();
    set_id(32'h104, 32'h0030_8233, 0, 1, 0); EXU_result = 32'h1234;
    cycle(ro, re); checks++;
    if (ro !== 1'b1 || EXU_rs1_val !== 32'h1234 || load_use_cnt !== 0) begin
      errors++; $display("FAIL ex_forward ready=%0b rs1=%0h cnt=%0d exp 1/1234/0", ro, EXU_rs1_val, load_use_cnt);
    end
  endtask

  task automatic test_load_use();
    set_id(32'h108, 32'h0002_a283, 1, 0, 0);
    cycle(ro, re);
    set_id(32'h10c, 32'h0002_8333, 0, 1, 0); EXU_result = 32'hdead;
    cycle(ro, re); checks++;
    if (ro !== 1'b0) begin errors++; $display("FAIL lu_ready got %0b exp 0", ro); end
    checks++;
    if ({EXU_valid, EXU_inst, EXU_mem_ren, EXU_R_Wen, load_use_cnt} !== {1'b0, NOP, 1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL lu_bubble valid=%0b inst=%0h ren=%0b cnt=%0d exp 0/13/0/1", EXU_valid, EXU_inst, EXU_mem_ren, load_use_cnt);
    end
    IDU_rs1_choice = 3; MEM_valid = 1; MEM_rdata = 32'hcafe;
    cycle(ro, re); checks++;
    if (ro !== 1'b1 || EXU_valid !== 1'b1 || EXU_rs1_val !== 32'hcafe) begin
      errors++; $display("FAIL lu_mem_fwd ready=%0b valid=%0b rs1=%0h exp 1/1/cafe", ro, EXU_valid, EXU_rs1_val);
    end
    MEM_valid = 0;
  endtask

  task automatic test_flush_priority();
    int c0;
    set_id(32'h110, 32'h0002_a283, 1, 0, 0);
    cycle(ro, re);
    c0 = m_cnt;
    set_id(32'h114, 32'h0002_8333, 0, 1, 0); EXU_ready = 0; flush = 1;
    cycle(ro, re); checks++;
    if (ro !== 1'b0 || EXU_valid !== 1'b0 || EXU_inst !== NOP || EXU_mem_ren !== 1'b0 || int'(load_use_cnt) !== c0) begin
      errors++; $display("FAIL flush_prio ready=%0b valid=%0b inst=%0h cnt=%0d exp 0/0/13/%0d", ro, EXU_valid, EXU_inst, load_use_cnt, c0);
    end
    flush = 0; EXU_ready = 1;
  endtask

  task automatic test_back_pressure();
    set_id(32'h200, 32'h0010_0093, 0, 0, 0); IDU_rs1_data = 32'haaaa;
    cycle(ro, re);
    EXU_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_id(32'h204 + 4 * i, $urandom, 0, 2'($urandom), 2'($urandom)); IDU_rs1_data = $urandom;
      cycle(ro, re); checks++;
      if (ro !== 1'b0 || EXU_valid !== 1'b1 || EXU_pc !== 32'h200 || EXU_rs1_val !== 32'haaaa) begin
        errors++; $display("FAIL bp_hold ready=%0b valid=%0b pc=%0h rs1=%0h exp 0/1/200/aaaa", ro, EXU_valid, EXU_pc, EXU_rs1_val);
      end
    end
    EXU_ready = 1; set_id(32'h300, 32'h0040_0113, 0, 0, 0);
    cycle(ro, re); checks++;
    if (EXU_pc !== 32'h300 || EXU_inst !== 32'h0040_0113) begin
      errors++; $display("FAIL bp_release pc=%0h inst=%0h exp 300/400113", EXU_pc, EXU_inst);
    end
  endtask

  task automatic test_saturation();
    set_id(32'h400, 32'h0002_a283, 1, 0, 0);
    cycle(ro, re);
    for (int k = 0; k < 5; k++) begin
      set_id(32'h404 + 4 * k, 32'h0002_a283, 1, 1, 0);
      cycle(ro, re); checks++;
      if (ro !== 1'b0 || EXU_valid !== 1'b0 || int'(load_use_cnt) !== m_cnt) begin
        errors++; $display("FAIL sat_bubble k=%0d ready=%0b valid=%0b cnt=%0d exp 0/0/%0d", k, ro, EXU_valid, load_use_cnt, m_cnt);
      end
      IDU_rs1_choice = 3; MEM_valid = 1; MEM_rdata = 32'h1000 + k;
      cycle(ro, re); MEM_valid = 0;
    end
    checks++;
    if (load_use_cnt !== 2'd3) begin errors++; $display("FAIL sat_final got %0d exp 3", load_use_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      IDU_valid = ($urandom_range(3) != 0); IDU_pc = $urandom; IDU_inst = $urandom; IDU_rd = 5'($urandom);
      IDU_imm = $urandom; IDU_R_Wen = 1'($urandom); IDU_mem_ren = ($urandom_range(2) == 0);
      IDU_mem_wen = 1'($urandom); IDU_rs1_data = $urandom; IDU_rs2_data = $urandom;
      IDU_rs1_choice = 2'($urandom); IDU_rs2_choice = 2'($urandom); EXU_result = $urandom;
      MEM_valid = 1'($urandom); MEM_alu_result = $urandom; MEM_rdata = $urandom;
      EXU_ready = ($urandom_range(3) != 0); flush = ($urandom_range(7) == 0);
      cycle(ro, re); checks++;
      if (ro !== re) begin errors++; $display("FAIL rnd_ready n=%0d got %0b exp %0b", n, ro, re); end
      checks++;
      if ({EXU_valid, EXU_inst, EXU_R_Wen, EXU_mem_ren, EXU_mem_wen} !== {m_valid, m_inst, m_rwen, m_mren, m_mwen} || int'(load_use_cnt) !== m_cnt) begin
        errors++; $display("FAIL rnd_ctrl n=%0d valid=%0b inst=%0h ctl=%0b%0b%0b cnt=%0d exp %0b/%0h/%0b%0b%0b/%0d", n, EXU_valid, EXU_inst,
          EXU_R_Wen, EXU_mem_ren, EXU_mem_wen, load_use_cnt, m_valid, m_inst, m_rwen, m_mren, m_mwen, m_cnt);
      end
      if (m_valid) begin
        checks++;
        if ({EXU_pc, EXU_rd, EXU_imm, EXU_rs1_val, EXU_rs2_val} !== {m_pc, m_rd, m_imm, m_rs1, m_rs2}) begin
          errors++; $display("FAIL rnd_data n=%0d pc=%0h rd=%0d imm=%0h rs1=%0h rs2=%0h exp %0h/%0d/%0h/%0h/%0h", n, EXU_pc, EXU_rd,
            EXU_imm, EXU_rs1_val, EXU_rs2_val, m_pc, m_rd, m_imm, m_rs1, m_rs2);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset_mid_stall();
    set_id(32'h500, 32'h0002_a283, 1, 0, 0);
    cycle(ro, re);
    set_id(32'h504, 32'h0002_8333, 0, 1, 0);
    #1; checks++;
    if (IDU_ready !== 1'b0) begin errors++; $display("FAIL ar_stall ready=%0b exp 0", IDU_ready); end
    #1 rst_n = 0;
    #1; checks++;
    if ({EXU_valid, EXU_pc, EXU_rs1_val, EXU_R_Wen, EXU_mem_ren, EXU_mem_wen, load_use_cnt} !== '0 || EXU_inst !== NOP) begin
      errors++; $display("FAIL ar_clear valid=%0b pc=%0h ren=%0b cnt=%0d inst=%0h exp 0/0/0/0/13", EXU_valid, EXU_pc, EXU_mem_ren, load_use_cnt, EXU_inst);
    end
    @(negedge clk); rst_n = 1; model_reset(); idle();
    cycle(ro, re); checks++;
    if (EXU_valid !== 1'b0 || load_use_cnt !== 0) begin
      errors++; $display("FAIL ar_after valid=%0b cnt=%0d exp 0/0", EXU_valid, load_use_cnt);
    end
  endtask

  initial begin
    idle(); model_reset();
    test_reset();
    test_alu_flow();
    test_ex_forward();
    test_load_use();
    test_flush_priority();
    test_back_pressure();
    test_saturation();
    test_random();
    test_async_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
